// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// -------------
// Shares one single-byte UART transmitter between two payload producers
// (XADC sample path on port 0, RNG output path on port 1). A round-robin
// arbiter picks a producer. Its payload is latched, and the scheduler then
// walks the frame out one byte at a time: sync, header, payload MSB-first,
// and an optional checksum. Each byte uses the transmitter's level
// start/done handshake.
//
// Optional feature:
//   UART_TX_SCHED_CKSUM_EN  when defined, a checksum byte (XOR of the header
//                           and all payload bytes) is appended to each frame.
//
// Parameters:
//   SYNC_BYTE   first byte of every frame
//   PAY_BYTES   payload bytes per frame (1..4)
//
// Ports:
//   clk          system clock
//   ap_rst       synchronous reset, active-high
//   req0_valid   producer 0 has a payload
//   req0_data    producer 0 payload
//   req0_ready   one-cycle pulse when producer 0's payload is taken
//   req1_valid   producer 1 has a payload
//   req1_data    producer 1 payload
//   req1_ready   one-cycle pulse when producer 1's payload is taken
//   tx_start     level start request to the transmitter, held per byte
//   tx_byte      byte for the transmitter, stable while tx_start is high
//   tx_done      transmitter done flag (set in/after stop bit, cleared at start bit)
//   busy         a frame is in progress
//   frame_cnt    completed frames, wrapping 16-bit count
module uart_tx_sched #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         PAY_BYTES = 2
) (
  input  logic                   clk,
  input  logic                   ap_rst,
  input  logic                   req0_valid,
  input  logic [PAY_BYTES*8-1:0] req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [PAY_BYTES*8-1:0] req1_data,
  output logic                   req1_ready,
  output logic                   tx_start,
  output logic [7:0]             tx_byte,
  input  logic                   tx_done,
  output logic                   busy,
  output logic [15:0]            frame_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ARM  = 3'd2,
    WAIT = 3'd3,
    REL  = 3'd4
  } state_t;

  // Index of the final byte in a frame.
`ifdef UART_TX_SCHED_CKSUM_EN
  localparam int LAST_IDX = PAY_BYTES + 2;
`else
  localparam int LAST_IDX = PAY_BYTES + 1;
`endif

  localparam logic [2:0] PAY_LEN = 3'(PAY_BYTES);

  state_t                 state, state_n;
  logic [2:0]             idx, idx_n;
  logic [PAY_BYTES*8-1:0] payload, payload_n;
  logic                   src, src_n;
  logic                   last_grant, last_grant_n;
  logic                   grant1;
  logic                   tx_start_n;
  logic [7:0]             tx_byte_n;
  logic                   req0_ready_n, req1_ready_n;
  logic                   busy_n;
  logic [15:0]            frame_cnt_n;
  logic [7:0]             header;
  logic [7:0]             cur_byte;

  assign header = {src, 4'b0000, PAY_LEN};

`ifdef UART_TX_SCHED_CKSUM_EN
  logic [7:0] checksum;

  // Running XOR over the header and the latched payload; the sync byte is
  // deliberately left out.
  always_comb begin
    checksum = header;
    for (int k = 0; k < PAY_BYTES; k++) begin
      checksum = checksum ^ payload[k*8 +: 8];
    end
  end
`endif

  // Byte selector for the current frame position. Payload bytes are ordered
  // MSB-first, so position 2 picks the top byte of the payload.
  always_comb begin
    cur_byte = SYNC_BYTE;
    if (idx == 3'd1) begin
      cur_byte = header;
    end
    for (int k = 0; k < PAY_BYTES; k++) begin
      if (idx == 3'(k + 2)) begin
        cur_byte = payload[(PAY_BYTES-k)*8-1 -: 8];
      end
    end
`ifdef UART_TX_SCHED_CKSUM_EN
    if (idx == 3'(PAY_BYTES + 2)) begin
      cur_byte = checksum;
    end
`endif
  end

  // Next-state and next-output logic. Every registered output is computed
  // here so that the sequential block below only copies values.
  // Producer 1 wins when it is the only one asking. It also wins a tie when
  // producer 0 was served last (last_grant == 0).
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    payload_n    = payload;
    src_n        = src;
    last_grant_n = last_grant;
    tx_start_n   = tx_start;
    tx_byte_n    = tx_byte;
    req0_ready_n = 1'b0;
    req1_ready_n = 1'b0;
    frame_cnt_n  = frame_cnt;
    grant1       = req1_valid && (!req0_valid || !last_grant);

    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          src_n        = grant1;
          payload_n    = grant1 ? req1_data : req0_data;
          req0_ready_n = !grant1;
          req1_ready_n = grant1;
          idx_n        = 3'd0;
          state_n      = LOAD;
        end
      end
      LOAD: begin
        tx_byte_n  = cur_byte;
        tx_start_n = 1'b1;
        state_n    = ARM;
      end
      ARM: begin
        // A done flag left over from the previous byte stays high until the
        // transmitter emits its start bit. Moving on only once it is low
        // prevents a stale done from ending this byte early.
        if (!tx_done) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (tx_done) begin
          tx_start_n = 1'b0;
          state_n    = REL;
        end
      end
      REL: begin
        // One low cycle lets the transmitter leave its stop state before
        // the next start request.
        if (idx == 3'(LAST_IDX)) begin
          frame_cnt_n  = frame_cnt + 16'd1;
          last_grant_n = src;
          state_n      = IDLE;
        end else begin
          idx_n   = idx + 3'd1;
          state_n = LOAD;
        end
      end
      default: begin
        tx_start_n = 1'b0;
        state_n    = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // State and output registers. Reset drops any frame in flight and
  // discards the latched payload. last_grant resets to 1 so that producer 0
  // wins the first tie.
  always_ff @(posedge clk) begin
    if (ap_rst) begin
      state      <= IDLE;
      idx        <= 3'd0;
      payload    <= '0;
      src        <= 1'b0;
      last_grant <= 1'b1;
      tx_start   <= 1'b0;
      tx_byte    <= 8'h00;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      payload    <= payload_n;
      src        <= src_n;
      last_grant <= last_grant_n;
      tx_start   <= tx_start_n;
      tx_byte    <= tx_byte_n;
      req0_ready <= req0_ready_n;
      req1_ready <= req1_ready_n;
      busy       <= busy_n;
      frame_cnt  <= frame_cnt_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched
// ----------------
// Bench for uart_tx_sched. A behavioural transmitter model drives the
// done flag. It leaves done high between bytes and adds a random start
// latency, so a stale done is always present when a byte starts. It also
// records every byte it accepts. Expected frames, arbitration winners and
// frame counts come from a frame-level reference model in this file.
// Honours UART_TX_SCHED_CKSUM_EN the same way the design does.
module tb_uart_tx_sched;

  localparam int         PB   = 2;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic          req0_valid = 1'b0;
  logic          req1_valid = 1'b0;
  logic [PB*8-1:0] req0_data = '0;
  logic [PB*8-1:0] req1_data = '0;
  logic          req0_ready, req1_ready;
  logic          tx_start, busy;
  logic [7:0]    tx_byte;
  logic          tx_done;
  logic [15:0]   frame_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         exp_cnt = 0;
  bit         model_last = 1'b1;
  int         r0_pulses = 0;
  int         r1_pulses = 0;

  uart_tx_sched #(.SYNC_BYTE(SYNC), .PAY_BYTES(PB)) dut (
    .clk        (clk),
    .ap_rst     (ap_rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tx_start   (tx_start),
    .tx_byte    (tx_byte),
    .tx_done    (tx_done),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  // Transmitter model: idle -> (start latency) accept byte, clear done ->
  // shift for a few cycles -> raise done and hold it until start drops.
  int m_state = 0;
  int m_cnt = 0;
  int m_lat = 0;
  always @(posedge clk) begin
    if (ap_rst) begin
      tx_done <= 1'b1;
      m_state <= 0;
      m_lat   <= 0;
    end else begin
      case (m_state)
        0: if (tx_start) begin
             if (m_lat == 0) begin
               rx_q.push_back(tx_byte);
               tx_done <= 1'b0;
               m_cnt   <= $urandom_range(1, 5);
               m_state <= 1;
             end else begin
               m_lat <= m_lat - 1;
             end
           end
        1: if (m_cnt == 0) begin
             tx_done <= 1'b1;
             m_state <= 2;
           end else begin
             m_cnt <= m_cnt - 1;
           end
        default: if (!tx_start) begin
             m_state <= 0;
             m_lat   <= $urandom_range(0, 3);
           end
      endcase
    end
  end

  // tx_byte must hold steady while tx_start stays high. Ready pulses must
  // last one cycle and never overlap.
  logic       prev_start = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  logic       prev_r0 = 1'b0;
  logic       prev_r1 = 1'b0;
  always @(negedge clk) begin
    if (tx_start === 1'b1 && prev_start === 1'b1) begin
      checks++;
      if (tx_byte !== prev_byte) begin
        errors++;
        $display("[TB] FAIL tx_byte_stable: got %02h, required %02h", tx_byte, prev_byte);
      end
    end
    if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
      checks++;
      if ((req0_ready && (prev_r0 || req1_ready)) || (req1_ready && prev_r1)) begin
        errors++;
        $display("[TB] FAIL ready_pulse_shape: r0=%b r1=%b prev r0=%b r1=%b, required single one-cycle pulse",
                 req0_ready, req1_ready, prev_r0, prev_r1);
      end
    end
    if (req0_ready === 1'b1) r0_pulses++;
    if (req1_ready === 1'b1) r1_pulses++;
    prev_start = tx_start;
    prev_byte  = tx_byte;
    prev_r0    = req0_ready;
    prev_r1    = req1_ready;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  // Reference frame: sync, header {src,0000,len}, payload MSB-first, and the
  // optional XOR checksum over header and payload.
  task automatic expect_frame(input bit src, input logic [PB*8-1:0] d);
    logic [7:0] h;
    logic [7:0] c;
    logic [7:0] b;
    h = {src, 4'b0000, 3'(PB)};
    exp_q.delete();
    exp_q.push_back(SYNC);
    exp_q.push_back(h);
    c = h;
    for (int k = 0; k < PB; k++) begin
      b = d[(PB-1-k)*8 +: 8];
      exp_q.push_back(b);
      c = c ^ b;
    end
`ifdef UART_TX_SCHED_CKSUM_EN
    exp_q.push_back(c);
`endif
  endtask

  function automatic string q2str(input logic [7:0] q[$]);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  function automatic bit frame_matches();
    if (rx_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (rx_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_grant(output int who);
    who = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req0_ready === 1'b1) begin who = 0; break; end
      if (req1_ready === 1'b1) begin who = 1; break; end
    end
  endtask

  task automatic wait_idle(output bit to);
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx_start !== 1'b0)   begin errors++; $display("[TB] FAIL reset_tx_start: got %b, required 0", tx_start); end
    checks++; if (tx_byte !== 8'h00)   begin errors++; $display("[TB] FAIL reset_tx_byte: got %02h, required 00", tx_byte); end
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req0_ready: got %b, required 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req1_ready: got %b, required 0", req1_ready); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_frame_cnt: got %0d, required 0", frame_cnt); end
    ap_rst = 1'b0;
    exp_cnt = 0;
    model_last = 1'b1;
    @(negedge clk);
  endtask

  // One producer alone: grant and first-byte timing, a single ready pulse,
  // the full byte stream and the frame count.
  task automatic test_single(input bit src, input logic [PB*8-1:0] d);
    bit to;
    int p0, p1;
    logic [7:0] r_own, r_oth;
    rx_q.delete();
    p0 = r0_pulses;
    p1 = r1_pulses;
    if (src) begin req1_data = d; req1_valid = 1'b1; end
    else     begin req0_data = d; req0_valid = 1'b1; end
    @(negedge clk);
    r_own = src ? {7'd0, req1_ready} : {7'd0, req0_ready};
    r_oth = src ? {7'd0, req0_ready} : {7'd0, req1_ready};
    checks++;
    if (r_own !== 8'd1 || r_oth !== 8'd0) begin
      errors++;
      $display("[TB] FAIL grant_ready src%0d: own=%0d other=%0d, required own=1 other=0", src, r_own, r_oth);
    end
    checks++;
    if (tx_start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL grant_cycle src%0d: tx_start=%b busy=%b, required 0/1", src, tx_start, busy);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1 || tx_byte !== SYNC) begin
      errors++;
      $display("[TB] FAIL first_byte src%0d: tx_start=%b tx_byte=%02h, required 1/%02h", src, tx_start, tx_byte, SYNC);
    end
    wait_idle(to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL frame_timeout src%0d: busy stuck at 1, required 0", src); end
    exp_cnt++;
    model_last = src;
    expect_frame(src, d);
    checks++;
    if (frame_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("[TB] FAIL frame_cnt src%0d: got %0d, required %0d", src, frame_cnt, exp_cnt);
    end
    checks++;
    if (!frame_matches()) begin
      errors++;
      $display("[TB] FAIL frame_bytes src%0d: got %s, required %s", src, q2str(rx_q), q2str(exp_q));
    end
    checks++;
    if ((r0_pulses - p0) + (r1_pulses - p1) !== 1) begin
      errors++;
      $display("[TB] FAIL ready_count src%0d: got %0d pulses, required 1", src, (r0_pulses - p0) + (r1_pulses - p1));
    end
  endtask

  // Random request patterns. The first iterations keep both producers
  // requesting continuously to exercise strict alternation.
  task automatic test_arbitration();
    int who, exp_who, pat;
    bit to, keep;
    logic [PB*8-1:0] won;
    rx_q.delete();
    for (int it = 0; it < 14; it++) begin
      if (!req0_valid && !req1_valid) begin
        pat = (it < 6) ? 2 : $urandom_range(0, 2);
        if (pat != 1) begin req0_valid = 1'b1; req0_data = (PB*8)'($urandom()); end
        if (pat != 0) begin req1_valid = 1'b1; req1_data = (PB*8)'($urandom()); end
      end
      exp_who = (req0_valid && req1_valid) ? (model_last ? 0 : 1) : (req1_valid ? 1 : 0);
      wait_grant(who);
      checks++;
      if (who !== exp_who) begin
        errors++;
        $display("[TB] FAIL arb_winner it%0d: got %0d, required %0d", it, who, exp_who);
      end
      if (who < 0) break;
      won  = (who == 1) ? req1_data : req0_data;
      keep = (it < 6) || ($urandom_range(0, 1) == 1);
      if (it == 13) keep = 1'b0;
      if (who == 1) begin req1_data = (PB*8)'($urandom()); req1_valid = keep; end
      else          begin req0_data = (PB*8)'($urandom()); req0_valid = keep; end
      wait_idle(to);
      checks++;
      if (to) begin errors++; $display("[TB] FAIL arb_timeout it%0d: busy stuck at 1, required 0", it); break; end
      exp_cnt++;
      model_last = who[0];
      expect_frame(who[0], won);
      checks++;
      if (frame_cnt !== 16'(exp_cnt)) begin
        errors++;
        $display("[TB] FAIL arb_frame_cnt it%0d: got %0d, required %0d", it, frame_cnt, exp_cnt);
      end
      checks++;
      if (!frame_matches()) begin
        errors++;
        $display("[TB] FAIL arb_frame_bytes it%0d: got %s, required %s", it, q2str(rx_q), q2str(exp_q));
      end
      rx_q.delete();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Reset while payload byte 1 is on the wire, then a tie that req0 must
  // win, with a complete frame starting from the sync byte.
  task automatic test_reset_mid_frame();
    int who;
    bit to, seen;
    logic [PB*8-1:0] d;
    rx_q.delete();
    req0_data  = (PB*8)'($urandom());
    req0_valid = 1'b1;
    wait_grant(who);
    req0_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (rx_q.size() >= 3) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL mid_reach_payload: got %0d bytes, required 3", rx_q.size()); end
    ap_rst = 1'b1;
    @(negedge clk);
    ap_rst = 1'b0;
    exp_cnt = 0;
    model_last = 1'b1;
    checks++;
    if (tx_start !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_state: tx_start=%b busy=%b frame_cnt=%0d ready=%b%b, required 0 0 0 00",
               tx_start, busy, frame_cnt, req0_ready, req1_ready);
    end
    @(negedge clk);
    rx_q.delete();
    d = (PB*8)'($urandom());
    req0_data  = d;
    req1_data  = (PB*8)'($urandom());
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    wait_grant(who);
    checks++;
    if (who !== 0) begin errors++; $display("[TB] FAIL post_reset_tie: got %0d, required 0", who); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle(to);
    checks++;
    if (to) begin errors++; $display("[TB] FAIL post_reset_timeout: busy stuck at 1, required 0"); end
    exp_cnt++;
    model_last = 1'b0;
    expect_frame(1'b0, d);
    checks++;
    if (frame_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("[TB] FAIL post_reset_frame_cnt: got %0d, required %0d", frame_cnt, exp_cnt);
    end
    checks++;
    if (!frame_matches()) begin
      errors++;
      $display("[TB] FAIL post_reset_frame_bytes: got %s, required %s", q2str(rx_q), q2str(exp_q));
    end
  endtask

  initial begin
    $display("[TB] starting uart_tx_sched bench");
    test_reset();
    test_single(1'b0, 16'h1234);
    test_single(1'b1, 16'hBEEF);
    test_arbitration();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
